// File: rtl/i2c_pkg.sv
// Shared definitions for the parameterised I2C register slave: FSM state
// encoding, byte-count and synchroniser-depth limits, and a small helper.
package i2c_pkg;

    localparam int MAX_NBYTE       = 4;
    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_SYNC_STAGES = 3;
    localparam int BYTE_CNT_W      = $clog2(MAX_NBYTE);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_DEV_ADDR  = 4'd1,
        ST_DEV_ACK   = 4'd2,
        ST_REG_ADDR  = 4'd3,
        ST_REG_ACK   = 4'd4,
        ST_WR_DATA   = 4'd5,
        ST_WR_ACK    = 4'd6,
        ST_RD_DATA   = 4'd7,
        ST_RD_ACK    = 4'd8,
        ST_WAIT_STOP = 4'd9
    } i2c_state_t;

    // Index of the last byte in a multi-byte field, in byte-counter width
    function automatic logic [BYTE_CNT_W-1:0] last_byte_idx(input int nbyte);
        return BYTE_CNT_W'(nbyte - 1);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises raw SCL/SDA into the clk domain and derives SCL edges plus
// START/STOP conditions from the synchronised values only.
module i2c_bus_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda_i,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES :
                            (SYNC_STAGES > MAX_SYNC_STAGES) ? MAX_SYNC_STAGES : SYNC_STAGES;

    logic [STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [STAGES-1:0] sda_sync_q, sda_sync_d;
    logic              scl_prev_q, scl_prev_d;
    logic              sda_prev_q, sda_prev_d;
    logic              scl_s;

    // Shift raw inputs through the synchroniser chains and keep last values
    always_comb begin
        scl_sync_d = {scl_sync_q[STAGES-2:0], scl};
        sda_sync_d = {sda_sync_q[STAGES-2:0], sda_i};
        scl_prev_d = scl_sync_q[STAGES-1];
        sda_prev_d = sda_sync_q[STAGES-1];
    end

    // Synchroniser registers reset to the idle (released) bus level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_s     = scl_sync_q[STAGES-1];
    assign sda_s     = sda_sync_q[STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave_param.sv
// I2C register-access slave: device address match, multi-byte register
// address, multi-byte write words with a single strobe, and burst reads.
// ACK states are entered on the 8th SCL rise and left on the 9th (ACK) rise,
// so sda_oe is asserted and released on the surrounding SCL falls.
module i2c_slave_param
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ID      = 7'h23,
    parameter int         ADDR_NBYTE  = 2,
    parameter int         DATA_NBYTE  = 2,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    scl,
    input  logic                    sda_i,
    output logic                    sda_oe,
    output logic [8*ADDR_NBYTE-1:0] reg_addr,
    output logic                    wr_en,
    output logic [8*DATA_NBYTE-1:0] wr_data,
    output logic                    rd_req,
    input  logic [8*DATA_NBYTE-1:0] rd_data,
    output logic                    start_o,
    output logic                    stop_o,
    output logic [3:0]              state_o,
    output logic                    busy
);

    localparam int AW = 8 * ADDR_NBYTE;
    localparam int DW = 8 * DATA_NBYTE;
    localparam logic [BYTE_CNT_W-1:0] LAST_ADDR = last_byte_idx(ADDR_NBYTE);
    localparam logic [BYTE_CNT_W-1:0] LAST_DATA = last_byte_idx(DATA_NBYTE);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_state_t            state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]            rx_byte_q, rx_byte_d;
    logic                  rw_q, rw_d;
    logic                  sda_oe_q, sda_oe_d;
    logic [AW-1:0]         reg_addr_q, reg_addr_d;
    logic [DW-1:0]         word_q, word_d;
    logic [DW-1:0]         wr_data_q, wr_data_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_req_q, rd_req_d;
    logic                  rd_load_q, rd_load_d;
    logic                  start_q, start_d;
    logic                  stop_q, stop_d;

    logic [7:0]            rx_next;
    logic [AW+7:0]         addr_shift;
    logic [DW+7:0]         word_shift;
    logic                  byte_done;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bus_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda_i     (sda_i),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign rx_next    = {rx_byte_q[6:0], sda_s};
    assign addr_shift = {reg_addr_q, rx_next};
    assign word_shift = {word_q, rx_next};
    assign byte_done  = scl_rise && (bit_cnt_q == 3'd7);

    // Next-state, counter and output logic; START/STOP override every state
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        rx_byte_d  = rx_byte_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        reg_addr_d = reg_addr_q;
        word_d     = word_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        rd_req_d   = 1'b0;
        rd_load_d  = rd_req_q;
        start_d    = start_det;
        stop_d     = stop_det;

        if (wr_en_q) reg_addr_d = reg_addr_q + AW'(1);
        if (rd_load_q) word_d = rd_data;

        if (start_det) begin
            state_d    = ST_DEV_ADDR;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = '0;
            sda_oe_d   = 1'b0;
            rd_load_d  = 1'b0;
        end else if (stop_det) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = '0;
            sda_oe_d   = 1'b0;
            rd_load_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_WAIT_STOP: sda_oe_d = 1'b0;
                ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
                    if (scl_fall) sda_oe_d = 1'b0;
                    if (scl_rise) begin
                        rx_byte_d = rx_next;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                    if (byte_done) begin
                        if (state_q == ST_DEV_ADDR) begin
                            rw_d    = rx_next[0];
                            state_d = (rx_next[7:1] == DEV_ID) ? ST_DEV_ACK : ST_WAIT_STOP;
                        end else if (state_q == ST_REG_ADDR) begin
                            reg_addr_d = addr_shift[AW-1:0];
                            state_d    = ST_REG_ACK;
                        end else begin
                            word_d  = word_shift[DW-1:0];
                            state_d = ST_WR_ACK;
                        end
                    end
                end
                ST_DEV_ACK: begin
                    if (scl_fall) sda_oe_d = 1'b1;
                    if (scl_rise) begin
                        byte_cnt_d = '0;
                        if (rw_q) begin
                            rd_req_d = 1'b1;
                            state_d  = ST_RD_DATA;
                        end else begin
                            state_d  = ST_REG_ADDR;
                        end
                    end
                end
                ST_REG_ACK: begin
                    if (scl_fall) sda_oe_d = 1'b1;
                    if (scl_rise) begin
                        if (byte_cnt_q == LAST_ADDR) begin
                            byte_cnt_d = '0;
                            state_d    = ST_WR_DATA;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                            state_d    = ST_REG_ADDR;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) sda_oe_d = 1'b1;
                    if (scl_rise) begin
                        state_d = ST_WR_DATA;
                        if (byte_cnt_q == LAST_DATA) begin
                            byte_cnt_d = '0;
                            wr_en_d    = 1'b1;
                            wr_data_d  = word_q;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (scl_fall) begin
                        sda_oe_d = ~word_q[DW-1];
                        word_d   = {word_q[DW-2:0], 1'b0};
                    end
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = ST_RD_ACK;
                    end
                end
                ST_RD_ACK: begin
                    if (scl_fall) sda_oe_d = 1'b0;
                    if (scl_rise) begin
                        state_d = sda_s ? ST_WAIT_STOP : ST_RD_DATA;
                        if (byte_cnt_q == LAST_DATA) begin
                            byte_cnt_d = '0;
                            reg_addr_d = reg_addr_q + AW'(1);
                            rd_req_d   = ~sda_s;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers; reset aborts any transfer silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= '0;
            rx_byte_q  <= 8'd0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            reg_addr_q <= '0;
            word_q     <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            rd_req_q   <= 1'b0;
            rd_load_q  <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            rx_byte_q  <= rx_byte_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            reg_addr_q <= reg_addr_d;
            word_q     <= word_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            rd_req_q   <= rd_req_d;
            rd_load_q  <= rd_load_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign reg_addr = reg_addr_q;
    assign wr_en    = wr_en_q;
    assign wr_data  = wr_data_q;
    assign rd_req   = rd_req_q;
    assign start_o  = start_q;
    assign stop_o   = stop_q;
    assign state_o  = state_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_slave_param.sv
// Bench for i2c_slave_param: a bit-level I2C master drives directed and
// random transactions; expectations come from a transaction-level model.
module tb_i2c_slave_param;

    localparam int Q = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        scl;
    logic        sda_m;
    logic        sda_i;
    logic        sda_oe;
    logic [15:0] reg_addr;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        rd_req;
    logic [15:0] rd_data;
    logic        start_o;
    logic        stop_o;
    logic [3:0]  state_o;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] wr_addr_log[$];
    logic [15:0] wr_data_log[$];
    logic [15:0] rd_addr_log[$];
    logic [15:0] tx_words[$];
    logic [15:0] rx_words[$];
    int          stop_cycles;
    int          start_cycles;
    logic        oe_seen;

    // Register-file content seen by reads: a fixed function of the address
    function automatic logic [15:0] rd_pattern(input logic [15:0] a);
        return {a[7:0] ^ 8'h55, a[15:8] ^ 8'h46};
    endfunction

    always #5 clk = ~clk;

    assign sda_i   = sda_m & ~sda_oe;
    assign rd_data = rd_pattern(reg_addr);

    i2c_slave_param dut (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda_i    (sda_i),
        .sda_oe   (sda_oe),
        .reg_addr (reg_addr),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .start_o  (start_o),
        .stop_o   (stop_o),
        .state_o  (state_o),
        .busy     (busy)
    );

    // Strobe monitor, sampled on the inactive clock edge
    always @(negedge clk) begin
        if (wr_en) begin
            wr_addr_log.push_back(reg_addr);
            wr_data_log.push_back(wr_data);
        end
        if (rd_req) rd_addr_log.push_back(reg_addr);
        if (stop_o) stop_cycles++;
        if (start_o) start_cycles++;
        if (sda_oe) oe_seen = 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wr_addr_log.delete();
        wr_data_log.delete();
        rd_addr_log.delete();
        rx_words.delete();
        stop_cycles  = 0;
        start_cycles = 0;
        oe_seen      = 1'b0;
    endtask

    task automatic bit_cycle(input logic b, output logic s);
        sda_m = b;
        repeat (Q) @(negedge clk);
        scl = 1'b1;
        repeat (Q) @(negedge clk);
        s = sda_i;
        repeat (Q) @(negedge clk);
        scl = 1'b0;
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        repeat (Q) @(negedge clk);
        scl = 1'b1;
        repeat (Q) @(negedge clk);
        sda_m = 1'b0;
        repeat (Q) @(negedge clk);
        scl = 1'b0;
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        repeat (Q) @(negedge clk);
        scl = 1'b1;
        repeat (Q) @(negedge clk);
        sda_m = 1'b1;
        repeat (2 * Q) @(negedge clk);
    endtask

    // Master sends one byte and reports whether the slave acknowledged it
    task automatic applyStimulus(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
        bit_cycle(1'b1, s);
        acked = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s);
            b[i] = s;
        end
        bit_cycle(nack, s);
    endtask

    task automatic do_write(input logic [15:0] addr, output logic all_ack);
        logic a;
        i2c_start();
        applyStimulus(8'h46, a);       all_ack = a;
        applyStimulus(addr[15:8], a);  all_ack &= a;
        applyStimulus(addr[7:0], a);   all_ack &= a;
        foreach (tx_words[i]) begin
            applyStimulus(tx_words[i][15:8], a); all_ack &= a;
            applyStimulus(tx_words[i][7:0], a);  all_ack &= a;
        end
    endtask

    task automatic do_read(input int nwords, output logic ack);
        logic [7:0] hi, lo;
        i2c_start();
        applyStimulus(8'h47, ack);
        for (int w = 0; w < nwords; w++) begin
            read_byte(1'b0, hi);
            read_byte(w == nwords - 1, lo);
            rx_words.push_back({hi, lo});
        end
    endtask

    task automatic check_writes(input logic [15:0] base);
        logic [15:0] exp_addr;
        checkOutput("wr_count", wr_addr_log.size(), tx_words.size());
        for (int i = 0; i < tx_words.size() && i < wr_addr_log.size(); i++) begin
            exp_addr = base + 16'(i);
            checkOutput($sformatf("wr_addr[%0d]", i), wr_addr_log[i], exp_addr);
            checkOutput($sformatf("wr_data[%0d]", i), wr_data_log[i], tx_words[i]);
        end
    endtask

    initial begin
        logic        ok;
        logic        s;
        logic [7:0]  b;
        logic [15:0] addr;
        logic [15:0] exp_addr;
        int          n;

        rst = 1'b1; scl = 1'b1; sda_m = 1'b1;
        clear_logs();
        repeat (4) @(negedge clk);
        checkOutput("rst_state", state_o, 4'd0);
        checkOutput("rst_sda_oe", sda_oe, 1'b0);
        checkOutput("rst_reg_addr", reg_addr, 16'h0000);
        checkOutput("rst_wr_data", wr_data, 16'h0000);
        checkOutput("rst_strobes", {wr_en, rd_req, start_o, stop_o, busy}, 5'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] write 0xABCD to 0x0010");
        clear_logs();
        tx_words = '{16'hABCD};
        do_write(16'h0010, ok);
        checkOutput("w1_busy", busy, 1'b1);
        i2c_stop();
        checkOutput("w1_all_ack", ok, 1'b1);
        check_writes(16'h0010);
        checkOutput("w1_state", state_o, 4'd0);
        checkOutput("w1_busy_end", busy, 1'b0);
        checkOutput("w1_stop_pulse", stop_cycles, 1);
        checkOutput("w1_start_pulse", start_cycles, 1);

        $display("[TB] set address 0x0010 then read one word");
        clear_logs();
        tx_words.delete();
        do_write(16'h0010, ok);
        do_read(1, s);
        checkOutput("r1_addr_ack", ok & s, 1'b1);
        checkOutput("r1_nwords", rx_words.size(), 1);
        if (rx_words.size() > 0) begin
            checkOutput("r1_byte0", rx_words[0][15:8], 8'h45);
            checkOutput("r1_byte1", rx_words[0][7:0], 8'h46);
        end
        checkOutput("r1_rd_req_count", rd_addr_log.size(), 1);
        if (rd_addr_log.size() > 0) checkOutput("r1_rd_req_addr", rd_addr_log[0], 16'h0010);
        checkOutput("r1_wait_stop", state_o, 4'd9);
        i2c_stop();
        checkOutput("r1_idle", state_o, 4'd0);

        $display("[TB] foreign device address 0x24");
        clear_logs();
        i2c_start();
        applyStimulus(8'h48, ok);
        checkOutput("na_no_ack", ok, 1'b0);
        checkOutput("na_state", state_o, 4'd9);
        applyStimulus(8'h12, ok);
        checkOutput("na_state_hold", state_o, 4'd9);
        i2c_stop();
        checkOutput("na_oe_never", oe_seen, 1'b0);
        checkOutput("na_strobes", wr_addr_log.size() + rd_addr_log.size(), 0);
        checkOutput("na_idle", state_o, 4'd0);

        $display("[TB] burst write wrapping at 0xFFFF");
        clear_logs();
        tx_words = '{16'h1234, 16'hBEEF};
        do_write(16'hFFFF, ok);
        i2c_stop();
        checkOutput("wrap_all_ack", ok, 1'b1);
        check_writes(16'hFFFF);

        $display("[TB] STOP after first data byte");
        clear_logs();
        i2c_start();
        applyStimulus(8'h46, ok);
        applyStimulus(8'h00, ok);
        applyStimulus(8'h20, ok);
        applyStimulus(8'h5A, ok);
        i2c_stop();
        checkOutput("part_no_wr", wr_addr_log.size(), 0);
        checkOutput("part_idle", state_o, 4'd0);
        checkOutput("part_stop_pulse", stop_cycles, 1);

        $display("[TB] reset during read");
        clear_logs();
        i2c_start();
        b = 8'h47;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
        sda_m = 1'b1;
        repeat (Q) @(negedge clk);
        scl = 1'b1;
        repeat (Q) @(negedge clk);
        checkOutput("rr_in_rd_data", state_o, 4'd7);
        checkOutput("rr_ack_driven", sda_oe, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("rr_oe_released", sda_oe, 1'b0);
        checkOutput("rr_state_idle", state_o, 4'd0);
        checkOutput("rr_not_busy", busy, 1'b0);
        scl = 1'b1; sda_m = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("rr_no_wr", wr_addr_log.size(), 0);
        checkOutput("rr_still_idle", state_o, 4'd0);

        $display("[TB] random transactions");
        for (int t = 0; t < 6; t++) begin
            clear_logs();
            addr = 16'($urandom);
            n    = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) begin
                tx_words.delete();
                for (int i = 0; i < n; i++) tx_words.push_back(16'($urandom));
                do_write(addr, ok);
                i2c_stop();
                checkOutput($sformatf("rw%0d_ack", t), ok, 1'b1);
                check_writes(addr);
            end else begin
                tx_words.delete();
                do_write(addr, ok);
                do_read(n, s);
                i2c_stop();
                checkOutput($sformatf("rr%0d_ack", t), ok & s, 1'b1);
                checkOutput($sformatf("rr%0d_nwords", t), rx_words.size(), n);
                checkOutput($sformatf("rr%0d_nreq", t), rd_addr_log.size(), n);
                for (int i = 0; i < n; i++) begin
                    exp_addr = addr + 16'(i);
                    if (i < rx_words.size())
                        checkOutput($sformatf("rr%0d_data%0d", t, i), rx_words[i], rd_pattern(exp_addr));
                    if (i < rd_addr_log.size())
                        checkOutput($sformatf("rr%0d_addr%0d", t, i), rd_addr_log[i], exp_addr);
                end
            end
            checkOutput($sformatf("rnd%0d_idle", t), state_o, 4'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
